// File: rtl/fft_twiddle_cmul.sv
// -----------------------------------------------------------------------------
// fft_twiddle_cmul
// Butterfly-side consumer of a 32-entry twiddle ROM pair. For every accepted
// sample it drives the ROM address, lines the ROM's one-cycle registered read
// up with the sample, and computes sample * W with round-half-up and
// saturation. Three register stages (S1 capture, S2 products, S3 sum/round)
// with valid/ready on both sides and full backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_re, in_im, in_last input sample (signed DW) and end-of-frame marker
//   tw_addr               twiddle ROM address (address of the sample on offer)
//   tw_re, tw_im          ROM read data, valid one cycle after tw_addr
//   out_valid/out_ready   output handshake
//   out_re, out_im        rounded, saturated product (signed DW)
//   out_last              in_last aligned with its product
//   sat_flag              sticky: some product saturated
//   frame_err             sticky: in_last seen away from the last address
// -----------------------------------------------------------------------------
module fft_twiddle_cmul #(
    parameter int DW       = 16,
    parameter int TW       = 16,
    parameter int TW_FRAC  = 8,
    parameter int TW_DEPTH = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          in_last,
    output logic [4:0]    tw_addr,
    input  logic [TW-1:0] tw_re,
    input  logic [TW-1:0] tw_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          sat_flag,
    output logic          frame_err
);

    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam logic [4:0] LAST_ADDR = 5'(TW_DEPTH - 1);
    localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (TW_FRAC - 1);
    localparam logic signed [DW-1:0] MAX_DW = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};

    // Round half up, drop TW_FRAC bits, clamp to DW bits; MSB of result = saturated.
    function automatic logic [DW:0] round_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] r;
        r = (x + RND) >>> TW_FRAC;
        if (r > SW'(MAX_DW)) begin
            round_sat = {1'b1, MAX_DW};
        end else if (r < SW'(MIN_DW)) begin
            round_sat = {1'b1, MIN_DW};
        end else begin
            round_sat = {1'b0, r[DW-1:0]};
        end
    endfunction

    logic [4:0]              cnt_q, cnt_d;
    logic                    frame_err_q, frame_err_d;
    logic                    stall_s, en_s, accept_s;
    // S1
    logic                    v1_q, l1_q;
    logic signed [DW-1:0]    ar_q, ai_q;
    // twiddle alignment
    logic                    en_q;
    logic signed [TW-1:0]    wr_sav_q, wi_sav_q, wr_s, wi_s;
    // S2
    logic                    v2_q, l2_q;
    logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    // S3
    logic signed [SW-1:0]    re_full_s, im_full_s;
    logic [DW:0]             re_rs_s, im_rs_s;
    logic                    out_valid_q, out_last_q, sat_q;
    logic [DW-1:0]           out_re_q, out_im_q;

    assign stall_s   = out_valid_q & ~out_ready;
    assign en_s      = ~stall_s;
    assign accept_s  = in_valid & en_s;
    assign in_ready  = en_s;
    assign tw_addr   = cnt_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign sat_flag  = sat_q;
    assign frame_err = frame_err_q;

    // Address counter next state and frame error detection.
    always_comb begin
        cnt_d       = cnt_q;
        frame_err_d = frame_err_q;
        if (accept_s) begin
            if (in_last) begin
                cnt_d = 5'd0;
                if (cnt_q != LAST_ADDR) begin
                    frame_err_d = 1'b1;
                end else begin
                    frame_err_d = frame_err_q;
                end
            end else if (cnt_q == LAST_ADDR) begin
                cnt_d = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The ROM re-reads the held address while stalled, so after a stalled edge
    // its output belongs to the next sample; use the word saved before the stall.
    always_comb begin
        wr_s = wr_sav_q;
        wi_s = wi_sav_q;
        if (en_q) begin
            wr_s = tw_re;
            wi_s = tw_im;
        end else begin
            wr_s = wr_sav_q;
            wi_s = wi_sav_q;
        end
    end

    // S3 combinational: complex sums, rounding and saturation.
    always_comb begin
        re_full_s = SW'(p_rr_q) - SW'(p_ii_q);
        im_full_s = SW'(p_ri_q) + SW'(p_ir_q);
        re_rs_s   = round_sat(re_full_s);
        im_rs_s   = round_sat(im_full_s);
    end

    // Counter, sticky frame error and twiddle save register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 5'd0;
            frame_err_q <= 1'b0;
            en_q        <= 1'b1;
            wr_sav_q    <= '0;
            wi_sav_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            en_q        <= en_s;
            if (en_q) begin
                wr_sav_q <= tw_re;
                wi_sav_q <= tw_im;
            end
        end
    end

    // Pipeline stages S1..S3, all advancing together when not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            ar_q        <= '0;
            ai_q        <= '0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            p_rr_q      <= '0;
            p_ii_q      <= '0;
            p_ri_q      <= '0;
            p_ir_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            sat_q       <= 1'b0;
        end else if (en_s) begin
            v1_q        <= in_valid;
            l1_q        <= in_last;
            ar_q        <= in_re;
            ai_q        <= in_im;
            v2_q        <= v1_q;
            l2_q        <= l1_q;
            p_rr_q      <= PW'(ar_q) * PW'(wr_s);
            p_ii_q      <= PW'(ai_q) * PW'(wi_s);
            p_ri_q      <= PW'(ar_q) * PW'(wi_s);
            p_ir_q      <= PW'(ai_q) * PW'(wr_s);
            out_valid_q <= v2_q;
            out_last_q  <= l2_q;
            out_re_q    <= re_rs_s[DW-1:0];
            out_im_q    <= im_rs_s[DW-1:0];
            sat_q       <= sat_q | (v2_q & (re_rs_s[DW] | im_rs_s[DW]));
        end
    end

endmodule

// File: tb/tb_fft_twiddle_cmul.sv
module tb_fft_twiddle_cmul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_re, in_im, tw_re, tw_im, out_re, out_im;
    logic [4:0]  tw_addr;
    logic        out_valid, out_ready, out_last, sat_flag, frame_err;

    always #5 clk = ~clk;

    fft_twiddle_cmul #(.DW(16), .TW(16), .TW_FRAC(8), .TW_DEPTH(28)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .sat_flag(sat_flag), .frame_err(frame_err)
    );

    // twiddle ROM pair: one-cycle registered read
    int rom_re[32];
    int rom_im[32];
    always @(posedge clk) begin
        tw_re <= 16'(rom_re[tw_addr]);
        tw_im <= 16'(rom_im[tw_addr]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // scoreboard
    int q_re[$];
    int q_im[$];
    bit q_last[$];
    int q_cyc[$];

    // reference state
    int ref_cnt  = 0;
    bit ref_ferr = 0;
    bit ref_sat  = 0;
    bit lat_chk  = 0;

    // behavioural complex multiply: exact product, round half up, clamp
    function automatic int scale_clamp(input longint v, inout bit s);
        longint r;
        r = (v + 128) >>> 8;
        if (r > 32767) begin s = 1; return 32767; end
        if (r < -32768) begin s = 1; return -32768; end
        return int'(r);
    endfunction

    task automatic push_expected(input int ar, input int ai, input bit last);
        longint wr, wi;
        bit s;
        s  = 0;
        wr = rom_re[ref_cnt];
        wi = rom_im[ref_cnt];
        q_re.push_back(scale_clamp(ar * wr - ai * wi, s));
        q_im.push_back(scale_clamp(ar * wi + ai * wr, s));
        q_last.push_back(last);
        q_cyc.push_back(lat_chk ? cyc + 3 : -1);
        if (s) ref_sat = 1;
        if (last) begin
            if (ref_cnt != 27) ref_ferr = 1;
            ref_cnt = 0;
        end else begin
            ref_cnt = (ref_cnt + 1) % 28;
        end
    endtask

    // offer one sample, wait for acceptance (bounded), check address, record expectation
    task automatic send(input int re, input int im, input bit last);
        bit done;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_last  = last;
        #1;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                check("tw_addr", tw_addr, ref_cnt);
                push_expected(re, im, last);
                done = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int n = 0; n < 200; n++) begin
            if (q_re.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", q_re.size(), 0);
        @(negedge clk);
        #3;
        check("sat_flag", sat_flag, ref_sat);
        check("frame_err", frame_err, ref_ferr);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        q_re.delete(); q_im.delete(); q_last.delete(); q_cyc.delete();
        ref_cnt = 0; ref_ferr = 0; ref_sat = 0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_tw_addr", tw_addr, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
    endtask

    task automatic rom_fill(input int wr, input int wi);
        for (int i = 0; i < 32; i++) begin rom_re[i] = wr; rom_im[i] = wi; end
    endtask

    task automatic rom_rand();
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = int'($urandom_range(0, 512)) - 256;
            rom_im[i] = int'($urandom_range(0, 512)) - 256;
        end
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 8000)) - 4000;
    endfunction

    // monitor: compare each transferred product against the scoreboard
    int  m_re, m_im, m_cyc;
    bit  m_last;
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q_re.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                m_re   = q_re.pop_front();
                m_im   = q_im.pop_front();
                m_last = q_last.pop_front();
                m_cyc  = q_cyc.pop_front();
                check("out_re", $signed(out_re), m_re);
                check("out_im", $signed(out_im), m_im);
                check("out_last", out_last, m_last);
                if (m_cyc >= 0) check("latency", cyc, m_cyc);
            end
        end
    end

    // downstream ready: directed stall window, optional random backpressure
    int   stall_req = 0;
    bit   rand_bp   = 0;
    bit   snap_ok   = 0;
    logic [4:0]  s_addr;
    logic [15:0] s_re, s_im;
    logic        s_v;
    always @(negedge clk) begin
        if (stall_req > 0) begin
            out_ready = 1'b0;
            stall_req = stall_req - 1;
            #1;
            check("stall_in_ready", in_ready, out_valid ? 0 : 1);
            if (snap_ok && s_v) begin
                check("stall_tw_addr", tw_addr, s_addr);
                check("stall_out_re", out_re, s_re);
                check("stall_out_im", out_im, s_im);
                check("stall_out_valid", out_valid, s_v);
            end
            s_addr = tw_addr; s_re = out_re; s_im = out_im; s_v = out_valid;
            snap_ok = 1;
        end else begin
            snap_ok = 0;
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
            else         out_ready = 1'b1;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = 16'h0000;
        in_im     = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // identity twiddle, latency and address sequence 0..4
        rom_fill(256, 0);
        rst_pulse();
        lat_chk = 1;
        for (int i = 0; i < 5; i++) send(1000, -500, 0);
        lat_chk = 0;
        drain();

        // ROM alignment: only address 5 carries W = -j
        rom_fill(0, 0);
        rom_re[5] = 0;
        rom_im[5] = -256;
        rst_pulse();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) send(200, 300, 0);
            else        send(rnd_s(), rnd_s(), 0);
        end
        drain();

        // frame wrap, then short frame error
        rom_rand();
        rst_pulse();
        for (int i = 0; i < 28; i++) send(rnd_s(), rnd_s(), i == 27);
        #1;
        check("frame_err_clean", frame_err, ref_ferr);
        for (int i = 0; i < 10; i++) send(rnd_s(), rnd_s(), i == 9);
        #1;
        check("frame_err_short", frame_err, ref_ferr);
        send(rnd_s(), rnd_s(), 0);
        drain();

        // directed stall mid-stream
        rom_rand();
        rst_pulse();
        for (int i = 0; i < 24; i++) begin
            if (i == 8) stall_req = 4;
            send(rnd_s(), rnd_s(), 0);
        end
        drain();

        // random bubbles and random backpressure
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(rnd_s(), rnd_s(), i == 27);
        end
        rand_bp = 0;
        drain();

        // rounding and saturation
        rom_fill(0, 0);
        rom_re[0] = 256; rom_im[0] = 256;
        rom_re[1] = 128; rom_im[1] = 0;
        rst_pulse();
        send(32767, 32767, 0);
        send(3, 0, 0);
        drain();

        // reset with samples in flight
        rom_rand();
        for (int i = 0; i < 3; i++) send(rnd_s(), rnd_s(), 0);
        rst_pulse();
        send(rnd_s(), rnd_s(), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
        $fatal(1);
    end

endmodule

// File: doc/fft_twiddle_cmul.md
Name: fft_twiddle_cmul

Overview:
- Butterfly-side consumer of the 32-entry twiddle ROM pair (real and imaginary, 5-bit address, 16-bit data, one-cycle registered read).
- Sequences the ROM address for each accepted sample, aligns the ROM's one-cycle read latency with the data path, and performs the complex multiply sample × W.
- Output goes to the next FFT butterfly stage.
- Streaming valid/ready interface on both sides; 3-cycle pipeline; full backpressure.

Parameters:
- DW, 16, sample component width (signed two's complement).
- TW, 16, twiddle width (signed, Q8: 16'h0100 = +1.0, 16'hFF00 = -1.0).
- TW_FRAC, 8, twiddle fractional bits; products are shifted right by this amount.
- TW_DEPTH, 28, twiddle entries used per frame; address runs 0..TW_DEPTH-1 (must be ≤ 32).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_re  in  DW  input real part
- in_im  in  DW  input imaginary part
- in_last  in  1  marks the final sample of a frame
- tw_addr  out  5  address to both twiddle ROMs
- tw_re  in  TW  real twiddle from ROM (valid one cycle after tw_addr)
- tw_im  in  TW  imaginary twiddle from ROM (valid one cycle after tw_addr)
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts the product
- out_re  out  DW  product real part
- out_im  out  DW  product imaginary part
- out_last  out  1  in_last delayed to align with its product
- sat_flag  out  1  sticky flag: any product saturated
- frame_err  out  1  sticky flag: in_last arrived with counter ≠ TW_DEPTH-1

Behaviour:
- Reset (async assert, sync release): tw_addr=0, all valid bits=0, out_re=out_im=0, out_last=0, sat_flag=0, frame_err=0, address counter=0.
- Stall and enable:
  - stall = out_valid & ~out_ready; en = ~stall; in_ready = en.
  - All pipeline registers update only when en=1.
  - tw_addr is held during a stall, so the ROM keeps presenting the same word.
- Accept: a sample is accepted when in_valid & in_ready. tw_addr itself is combinational from the counter and is the address of the sample being accepted.
- Counter:
  - On accept it increments; it wraps to 0 after TW_DEPTH-1.
  - On accept with in_last=1 it forces 0.
  - If in_last=1 and the counter ≠ TW_DEPTH-1, frame_err is set (sticky) and the counter still resyncs to 0.
  - If the counter reaches TW_DEPTH-1 without in_last, it wraps silently.
- S1 (accept edge): register in_re, in_im, in_last and the valid bit. The ROM registers tw_re/tw_im on the same edge.
- S2: four signed products ar·wr, ai·wi, ar·wi, ai·wr, each DW+TW bits, registered.
- S3:
  - re = ar·wr − ai·wi; im = ar·wi + ai·wr, computed at DW+TW+1 bits.
  - Add 2^(TW_FRAC−1), arithmetic shift right by TW_FRAC (round half up).
  - Saturate to DW bits: max 16'h7FFF, min 16'h8000. Any saturation sets sat_flag.
  - Register into out_re/out_im/out_valid/out_last.
- Latency: accept edge to out_valid is 3 clocks when not stalled. Throughput is 1 sample/clock.
- Bubbles (in_valid=0) travel as valid=0 slots and do not advance the counter.
- Simultaneous cases:
  - out_ready=0 with out_valid=0 does not stall; bubbles are squeezed out.
  - in_last and wrap on the same sample yields one resync to 0, no error.
- Reset mid-frame: pipeline is flushed, counter=0; sticky flags clear only on reset.

Test Plan:
- Identity: twiddle model returns 16'h0100/16'h0000 for all addresses. Feed (1000, −500) × 5 with out_ready=1 → outputs (1000, −500), first at 3 cycles after accept, tw_addr sequence 0,1,2,3,4.
- ROM alignment:
  - Model returns W=(0, FF00 → −1.0) for addr 5 and (0,0) elsewhere.
  - Feed 6 samples, sample 5 = (200, 300) → output 5 = (300, −200); all others (0, 0).
- Frame wrap and error:
  - 28 samples with in_last on #27 → tw_addr 0..27 then 0, frame_err=0.
  - Then in_last on the 10th sample of the next frame → frame_err=1, next tw_addr=0.
- Backpressure:
  - Hold out_ready=0 for 4 cycles mid-stream → in_ready=0, tw_addr and out_* frozen, no sample lost or duplicated.
  - After release, the output sequence matches the reference model exactly.
- Rounding and saturation:
  - (7FFF, 7FFF) × W=(0100, 0100) → out_re=0000, out_im saturates to 7FFF, sat_flag=1.
  - (3, 0) × W=(0080, 0) → out_re=2 (1.5 rounds up).
- Reset mid-operation: assert rst_n=0 with 3 samples in flight → out_valid=0 immediately; after release, the next accepted sample uses tw_addr=0.
